// File: rtl/slice_serial_adder.sv
// slice_serial_adder: multi-cycle add/subtract, SLICE bits per clock with valid/ready handshakes
module slice_serial_adder #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic c_r;
  logic [IW-1:0] idx;
  logic [SLICE:0] r;
  logic [WIDTH+SLICE-1:0] t;
  logic last;
  assign in_ready = state == IDLE;
  assign r = {1'b0, a_r[SLICE-1:0]} + {1'b0, b_r[SLICE-1:0]} + {{SLICE{1'b0}}, c_r};
  assign t = {r[SLICE-1:0], sum};
  assign last = idx == IW'(NSLICE - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      c_r       <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= sub ? ~b : b;
          c_r   <= sub | cin;
          idx   <= '0;
          state <= CALC;
        end
        CALC: begin
          sum <= t[WIDTH+SLICE-1:SLICE];
          a_r <= a_r >> SLICE;
          b_r <= b_r >> SLICE;
          c_r <= r[SLICE];
          idx <= last ? '0 : idx + 1'b1;
          if (last) begin
            carry     <= r[SLICE];
            overflow  <= a_r[SLICE-1] ^ b_r[SLICE-1] ^ r[SLICE-1] ^ r[SLICE];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_slice_serial_adder.sv
// tb_slice_serial_adder: scoreboard bench over three slice_serial_adder configurations
module tb_slice_serial_adder;
  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    int         acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int nchk = 0;
  int nfail = 0;
  exp_t q[3][$];
  int ns[3] = '{4, 4, 1};
  logic pv[3] = '{1'b0, 1'b0, 1'b0};
  logic iv0 = 0, ir0, cin0 = 0, sub0 = 0, ov0, ordy0 = 1, c0, v0;
  logic [7:0] a0 = 0, b0 = 0, s0;
  logic iv1 = 0, ir1, cin1 = 0, sub1 = 0, ov1, ordy1 = 1, c1, v1;
  logic [3:0] a1 = 0, b1 = 0, s1;
  logic iv2 = 0, ir2, cin2 = 0, sub2 = 0, ov2, ordy2 = 1, c2, v2;
  logic [7:0] a2 = 0, b2 = 0, s2;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  slice_serial_adder #(.WIDTH(8), .SLICE(2)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
    .a(a0), .b(b0), .cin(cin0), .sub(sub0), .out_valid(ov0), .out_ready(ordy0), .sum(s0), .carry(c0), .overflow(v0));
  slice_serial_adder #(.WIDTH(4), .SLICE(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(ordy1), .sum(s1), .carry(c1), .overflow(v1));
  slice_serial_adder #(.WIDTH(8), .SLICE(8)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .a(a2), .b(b2), .cin(cin2), .sub(sub2), .out_valid(ov2), .out_ready(ordy2), .sum(s2), .carry(c2), .overflow(v2));
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask
  function automatic logic [9:0] model(int w, int a, int b, logic cin, logic sub);
    int m, bb, s, full;
    logic c, v;
    m = (1 << w) - 1;
    bb = sub ? (~b & m) : (b & m);
    full = (a & m) + bb + int'(sub ? 1'b1 : cin);
    s = full & m;
    c = full[w];
    v = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {v, c, s[7:0]};
  endfunction
  task automatic mon(int id, logic valid, logic rdy, logic [7:0] s, logic c, logic v);
    exp_t e;
    if (valid && !pv[id] && q[id].size() > 0)
      chk($sformatf("latency%0d", id), cyc - q[id][0].acc, ns[id]);
    if (valid && rdy) begin
      if (q[id].size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL unexpected_out%0d: got sum %0h, expected no result", id, s);
      end else begin
        e = q[id].pop_front();
        chk($sformatf("sum%0d", id), s, e.s);
        chk($sformatf("carry%0d", id), c, e.c);
        chk($sformatf("ovf%0d", id), v, e.v);
      end
    end
    pv[id] = valid;
  endtask
  always @(negedge clk) begin
    mon(0, ov0, ordy0, s0, c0, v0);
    mon(1, ov1, ordy1, {4'b0, s1}, c1, v1);
    mon(2, ov2, ordy2, s2, c2, v2);
  end
  task automatic drive(int id, logic vld, logic [7:0] a, logic [7:0] b, logic cin, logic sub);
    case (id)
      0: begin iv0 = vld; a0 = a; b0 = b; cin0 = cin; sub0 = sub; end
      1: begin iv1 = vld; a1 = a[3:0]; b1 = b[3:0]; cin1 = cin; sub1 = sub; end
      default: begin iv2 = vld; a2 = a; b2 = b; cin2 = cin; sub2 = sub; end
    endcase
  endtask
  task automatic issue(int id, logic [7:0] a, logic [7:0] b, logic cin, logic sub, bit push,
                       logic [7:0] es, logic ec, logic ev);
    bit ok;
    ok = 0;
    @(posedge clk) #1 drive(id, 1'b1, a, b, cin, sub);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = id == 0 ? ir0 : id == 1 ? ir1 : ir2;
    end
    if (!ok) begin
      nchk++;
      nfail++;
      $display("FAIL accept_timeout%0d: got in_ready 0, expected 1", id);
    end else if (push) q[id].push_back('{es, ec, ev, cyc + 1});
    @(posedge clk) #1 drive(id, 1'b0, a, b, cin, sub);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [9:0] r;
    bit ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", ir0, 1);
    chk("rst_out_valid", ov0, 0);
    chk("rst_sum", s0, 0);
    chk("rst_carry", c0, 0);
    chk("rst_ovf", v0, 0);
    @(posedge clk) #1 rst_n = 1'b1;
    issue(0, 8'hFF, 8'h01, 0, 0, 1, 8'h00, 1, 0);
    issue(0, 8'h05, 8'h07, 0, 1, 1, 8'hFE, 0, 0);
    issue(0, 8'h80, 8'h01, 0, 1, 1, 8'h7F, 1, 1);
    issue(0, 8'h7F, 8'h7F, 1, 1, 1, 8'h00, 1, 0);
    issue(0, 8'h12, 8'h34, 1, 0, 1, 8'h47, 0, 0);
    issue(2, 8'h40, 8'h40, 0, 0, 1, 8'h80, 0, 1);
    issue(2, 8'hC0, 8'h50, 1, 1, 1, 8'h70, 1, 1);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int k = 0; k < 4; k++) begin
          r = model(4, a, b, k[0], k[1]);
          issue(1, 8'(a), 8'(b), k[0], k[1], 1, r[7:0], r[8], r[9]);
        end
    @(posedge clk) #1 ordy0 = 1'b0;
    issue(0, 8'h12, 8'h34, 0, 0, 1, 8'h46, 0, 0);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = ov0;
    end
    chk("bp_valid_rise", ov0, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk) #1 drive(0, 1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b1);
      @(negedge clk);
      chk("bp_valid", ov0, 1);
      chk("bp_in_ready", ir0, 0);
      chk("bp_sum", s0, 8'h46);
      chk("bp_carry", c0, 0);
      chk("bp_ovf", v0, 0);
    end
    @(posedge clk) #1 begin iv0 = 1'b0; ordy0 = 1'b1; end
    @(posedge clk) #1;
    @(negedge clk);
    chk("bp_release_valid", ov0, 0);
    chk("bp_release_ready", ir0, 1);
    issue(0, 8'h11, 8'h22, 0, 0, 0, 8'h00, 0, 0);
    @(posedge clk) #1 rst_n = 1'b0;
    #1;
    chk("abort_valid", ov0, 0);
    chk("abort_sum", s0, 0);
    chk("abort_ready", ir0, 1);
    @(posedge clk) #1 rst_n = 1'b1;
    issue(0, 8'h3C, 8'h0F, 0, 0, 1, 8'h4B, 0, 0);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0;
    end
    chk("drain0", q[0].size(), 0);
    chk("drain1", q[1].size(), 0);
    chk("drain2", q[2].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
